// File: rtl/pkg_soc_interconnect.sv
// Shared SoC interconnect types: default TCDM field widths and the request struct.
package pkg_soc_interconnect;

  localparam int TCDM_ADDR_WIDTH = 32;
  localparam int TCDM_DATA_WIDTH = 32;
  localparam int TCDM_BE_WIDTH   = 4;

  typedef struct packed {
    logic [TCDM_ADDR_WIDTH-1:0] add;
    logic                       wen;
    logic [TCDM_DATA_WIDTH-1:0] wdata;
    logic [TCDM_BE_WIDTH-1:0]   be;
  } tcdm_req_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tcdm_rr_arbiter_if.sv
// Bundle of the NR_MASTERS-wide master side and the single slave side of the TCDM arbiter.
interface tcdm_rr_arbiter_if #(
  parameter int NR_MASTERS = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4
);
  // TCDM handshake: a request is accepted in the cycle where req and gnt are both high;
  // req and its fields stay stable until then. Each accepted request gets exactly one
  // rvalid, in order, no earlier than the cycle after its grant. rdata/ropc are broadcast.
  logic [NR_MASTERS-1:0]            m_req;
  logic [NR_MASTERS*ADDR_WIDTH-1:0] m_add;
  logic [NR_MASTERS-1:0]            m_wen;
  logic [NR_MASTERS*DATA_WIDTH-1:0] m_wdata;
  logic [NR_MASTERS*BE_WIDTH-1:0]   m_be;
  logic [NR_MASTERS-1:0]            m_gnt;
  logic [NR_MASTERS-1:0]            m_rvalid;
  logic [DATA_WIDTH-1:0]            m_rdata;
  logic                             m_ropc;

  logic                             s_req;
  logic [ADDR_WIDTH-1:0]            s_add;
  logic                             s_wen;
  logic [DATA_WIDTH-1:0]            s_wdata;
  logic [BE_WIDTH-1:0]              s_be;
  logic                             s_gnt;
  logic                             s_rvalid;
  logic [DATA_WIDTH-1:0]            s_rdata;
  logic                             s_ropc;

  // slave: the arbiter's view (it serves the masters and drives the shared target).
  modport slave (
    input  m_req, m_add, m_wen, m_wdata, m_be, s_gnt, s_rvalid, s_rdata, s_ropc,
    output m_gnt, m_rvalid, m_rdata, m_ropc, s_req, s_add, s_wen, s_wdata, s_be
  );

  // master: the surrounding system's view (requesting masters plus the target).
  modport master (
    output m_req, m_add, m_wen, m_wdata, m_be, s_gnt, s_rvalid, s_rdata, s_ropc,
    input  m_gnt, m_rvalid, m_rdata, m_ropc, s_req, s_add, s_wen, s_wdata, s_be
  );
endinterface

// File: rtl/tcdm_arb_id_fifo.sv
// In-order FIFO of granted master indices; the head tells where the next response goes.
module tcdm_arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;
  logic             push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // full is taken from the registered count, so a same-cycle pop never frees a slot for a push.
  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= ptr_inc(wr_q);
      if (pop_ok)  rd_q <= ptr_inc(rd_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM slave port between NR_MASTERS masters,
// with an in-order ID FIFO routing responses back to the issuing master.
module tcdm_rr_arbiter
  import pkg_soc_interconnect::*;
#(
  parameter int NR_MASTERS      = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_WIDTH      = TCDM_ADDR_WIDTH,
  parameter int DATA_WIDTH      = TCDM_DATA_WIDTH,
  parameter int BE_WIDTH        = TCDM_BE_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  tcdm_rr_arbiter_if.slave    bus,
  output logic                err_o
);
  localparam int IDX_WIDTH = $clog2(NR_MASTERS);

  logic [IDX_WIDTH-1:0] ptr_q, sel_q, arb_sel, sel, head;
  logic                 lock_q, found, handshake, pop, fifo_full, fifo_empty;

  // Cyclic search starting at the priority pointer.
  always_comb begin
    arb_sel = ptr_q;
    found   = 1'b0;
    for (int i = 0; i < NR_MASTERS; i++) begin
      if (!found && bus.m_req[IDX_WIDTH'((int'(ptr_q) + i) % NR_MASTERS)]) begin
        found   = 1'b1;
        arb_sel = IDX_WIDTH'((int'(ptr_q) + i) % NR_MASTERS);
      end
    end
  end

  // A request offered but not granted keeps the slave fields pinned to the same master.
  assign sel       = lock_q ? sel_q : arb_sel;
  assign handshake = bus.s_req && bus.s_gnt;
  assign pop       = bus.s_rvalid && !fifo_empty;

  always_comb begin
    bus.s_req   = bus.m_req[sel] && !fifo_full;
    bus.s_add   = '0;
    bus.s_wen   = 1'b1;
    bus.s_wdata = '0;
    bus.s_be    = '0;
    if (bus.m_req[sel]) begin
      bus.s_add   = bus.m_add[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.s_wen   = bus.m_wen[sel];
      bus.s_wdata = bus.m_wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
      bus.s_be    = bus.m_be[int'(sel)*BE_WIDTH +: BE_WIDTH];
    end
    bus.m_gnt         = '0;
    bus.m_gnt[sel]    = handshake;
    bus.m_rvalid      = '0;
    bus.m_rvalid[head] = pop;
    bus.m_rdata       = bus.s_rvalid ? bus.s_rdata : '0;
    bus.m_ropc        = bus.s_rvalid && bus.s_ropc;
    err_o             = bus.s_rvalid && fifo_empty;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      sel_q  <= '0;
      lock_q <= 1'b0;
    end else if (handshake) begin
      ptr_q  <= IDX_WIDTH'(wrap_inc(int'(sel), NR_MASTERS));
      lock_q <= 1'b0;
    end else if (bus.s_req) begin
      lock_q <= 1'b1;
      sel_q  <= sel;
    end
  end

  tcdm_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_WIDTH)
  ) u_id_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (handshake),
    .pop   (pop),
    .data  (sel),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );
endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// Directed bench for tcdm_rr_arbiter: stimulus pushes expected grants/responses, a monitor checks them.
module tb_tcdm_rr_arbiter;
  import pkg_soc_interconnect::*;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;

  tcdm_rr_arbiter_if #(.NR_MASTERS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

  tcdm_rr_arbiter #(
    .NR_MASTERS(NR), .MAX_OUTSTANDING(MO), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .err_o (err)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [NR-1:0]   exp_gnt_q[$];
  logic [NR+DW:0]  exp_rsp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  logic [NR-1:0] fair_gnt_tab [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_master(input int i, input tcdm_req_t r);
    bus.m_add[i*AW +: AW]   = r.add;
    bus.m_wen[i]            = r.wen;
    bus.m_wdata[i*DW +: DW] = r.wdata;
    bus.m_be[i*BW +: BW]    = r.be;
  endtask

  task automatic idle();
    bus.m_req    = '0;
    bus.s_gnt    = 1'b0;
    bus.s_rvalid = 1'b0;
    bus.s_rdata  = '0;
    bus.s_ropc   = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NR-1:0] req, input logic gnt, input logic rv,
                       input logic [DW-1:0] rdata, input logic ropc);
    bus.m_req    = req;
    bus.s_gnt    = gnt;
    bus.s_rvalid = rv;
    bus.s_rdata  = rdata;
    bus.s_ropc   = ropc;
  endtask

  task automatic push_rsp(input logic [NR-1:0] who, input logic ropc, input logic [DW-1:0] d);
    exp_rsp_q.push_back({who, ropc, d});
  endtask

  task automatic reset_pulse();
    idle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (|bus.m_gnt) begin
      if (exp_gnt_q.size() == 0) check("unexpected_gnt", 64'(bus.m_gnt), 64'd0);
      else check("gnt", 64'(bus.m_gnt), 64'(exp_gnt_q.pop_front()));
    end
    if (|bus.m_rvalid) begin
      if (exp_rsp_q.size() == 0) check("unexpected_rvalid", 64'(bus.m_rvalid), 64'd0);
      else check("rsp", 64'({bus.m_rvalid, bus.m_ropc, bus.m_rdata}), 64'(exp_rsp_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    for (int i = 0; i < NR; i++)
      set_master(i, '{add: 32'hA000_0000 + 32'(i) * 32'h100, wen: 1'b1, wdata: '0, be: '0});
    rst = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_s_req", 64'(bus.s_req), 64'd0);
    check("rst_s_wen", 64'(bus.s_wen), 64'd1);
    check("rst_s_add", 64'(bus.s_add), 64'd0);
    check("rst_m_gnt", 64'(bus.m_gnt), 64'd0);
    check("rst_m_rvalid", 64'(bus.m_rvalid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    next_cycle();
    rst = 1'b0;

    // single master, zero-cycle grant, response next cycle
    drive(4'b0001, 1'b1, 1'b0, 32'h1234_5678, 1'b0);
    exp_gnt_q.push_back(4'b0001);
    @(negedge clk);
    check("single_s_req", 64'(bus.s_req), 64'd1);
    check("single_s_add", 64'(bus.s_add), 64'hA000_0000);
    check("rdata_forced_zero", 64'(bus.m_rdata), 64'd0);
    next_cycle();
    drive(4'b0000, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    push_rsp(4'b0001, 1'b0, 32'hDEAD_BEEF);
    @(negedge clk);
    check("single_err", 64'(err), 64'd0);
    next_cycle();
    reset_pulse();

    // fairness: everyone requests, grants rotate, responses follow one cycle behind
    for (int k = 0; k < 6; k++) begin
      drive((k < 5) ? 4'b1111 : 4'b0000, k < 5, k > 0, 32'hC0DE_0000 + 32'(k), 1'b0);
      if (k < 5) exp_gnt_q.push_back(fair_gnt_tab[k]);
      if (k > 0) push_rsp(fair_gnt_tab[k-1], 1'b0, 32'hC0DE_0000 + 32'(k));
      next_cycle();
    end
    idle();
    next_cycle();

    // lock: master 2 (a write) holds the port while stalled, master 1 shows up meanwhile
    set_master(2, '{add: 32'hA000_0200, wen: 1'b0, wdata: 32'h5555_AAAA, be: 4'b0011});
    drive(4'b1100, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("lock_s_req", 64'(bus.s_req), 64'd1);
    check("lock_s_wen", 64'(bus.s_wen), 64'd0);
    check("lock_s_wdata", 64'(bus.s_wdata), 64'h5555_AAAA);
    check("lock_s_be", 64'(bus.s_be), 64'h3);
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      drive(4'b1110, 1'b0, 1'b0, '0, 1'b0);
      @(negedge clk);
      check("lock_s_add_held", 64'(bus.s_add), 64'hA000_0200);
    end
    next_cycle();
    drive(4'b1110, 1'b1, 1'b0, '0, 1'b0);
    exp_gnt_q.push_back(4'b0100);
    @(negedge clk);
    check("lock_gnt_add", 64'(bus.s_add), 64'hA000_0200);
    next_cycle();
    drive(4'b1010, 1'b1, 1'b0, '0, 1'b0);
    exp_gnt_q.push_back(4'b1000);
    @(negedge clk);
    check("lock_next_add", 64'(bus.s_add), 64'hA000_0300);
    next_cycle();
    drive(4'b0010, 1'b1, 1'b1, 32'h0000_2222, 1'b1);
    push_rsp(4'b0100, 1'b1, 32'h0000_2222);
    @(negedge clk);
    check("lock_full_s_req", 64'(bus.s_req), 64'd0);
    next_cycle();
    drive(4'b0010, 1'b1, 1'b1, 32'h0000_3333, 1'b0);
    exp_gnt_q.push_back(4'b0010);
    push_rsp(4'b1000, 1'b0, 32'h0000_3333);
    @(negedge clk);
    check("b2b_s_req", 64'(bus.s_req), 64'd1);
    next_cycle();
    drive(4'b0000, 1'b0, 1'b1, 32'h0000_1111, 1'b0);
    push_rsp(4'b0010, 1'b0, 32'h0000_1111);
    next_cycle();
    set_master(2, '{add: 32'hA000_0200, wen: 1'b1, wdata: '0, be: '0});
    reset_pulse();

    // full FIFO: two grants, third request blocked, pop does not free a slot in the same cycle
    drive(4'b0001, 1'b1, 1'b0, '0, 1'b0);
    exp_gnt_q.push_back(4'b0001);
    next_cycle();
    drive(4'b0010, 1'b1, 1'b0, '0, 1'b0);
    exp_gnt_q.push_back(4'b0010);
    next_cycle();
    drive(4'b0100, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("full_s_req", 64'(bus.s_req), 64'd0);
    next_cycle();
    drive(4'b0100, 1'b1, 1'b1, 32'h0000_4000, 1'b0);
    push_rsp(4'b0001, 1'b0, 32'h0000_4000);
    @(negedge clk);
    check("full_pop_same_cycle", 64'(bus.s_req), 64'd0);
    next_cycle();
    drive(4'b0100, 1'b1, 1'b1, 32'h0000_4001, 1'b0);
    exp_gnt_q.push_back(4'b0100);
    push_rsp(4'b0010, 1'b0, 32'h0000_4001);
    @(negedge clk);
    check("after_pop_s_req", 64'(bus.s_req), 64'd1);
    next_cycle();
    drive(4'b0000, 1'b0, 1'b1, 32'h0000_4002, 1'b0);
    push_rsp(4'b0100, 1'b0, 32'h0000_4002);
    next_cycle();

    // stray response with nothing outstanding
    drive(4'b0000, 1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0);
    @(negedge clk);
    check("err_pulse", 64'(err), 64'd1);
    next_cycle();
    idle();
    @(negedge clk);
    check("err_clear", 64'(err), 64'd0);
    next_cycle();

    // pointer wraps 3 -> 0, then reset with two outstanding
    drive(4'b1000, 1'b1, 1'b0, '0, 1'b0);
    exp_gnt_q.push_back(4'b1000);
    next_cycle();
    drive(4'b1111, 1'b1, 1'b0, '0, 1'b0);
    exp_gnt_q.push_back(4'b0001);
    next_cycle();
    idle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(4'b0000, 1'b0, 1'b1, 32'h0000_0BAD, 1'b0);
    @(negedge clk);
    check("post_rst_s_wen", 64'(bus.s_wen), 64'd1);
    check("post_rst_s_req", 64'(bus.s_req), 64'd0);
    check("post_rst_lost_rsp_err", 64'(err), 64'd1);
    next_cycle();
    drive(4'b1111, 1'b1, 1'b0, '0, 1'b0);
    exp_gnt_q.push_back(4'b0001);
    next_cycle();
    drive(4'b0000, 1'b0, 1'b1, 32'h0000_5000, 1'b0);
    push_rsp(4'b0001, 1'b0, 32'h0000_5000);
    next_cycle();
    idle();
    repeat (3) next_cycle();

    check("gnt_queue_drained", 64'(exp_gnt_q.size()), 64'd0);
    check("rsp_queue_drained", 64'(exp_rsp_q.size()), 64'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
